// File: rtl/sd_host_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sd_host_pkg: shared SD host types and constants (clock FSM, divisor limits) |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package sd_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } sd_clk_state_t;

  localparam int SD_SYS_CLK_HZ = 50_000_000;
  localparam int SD_IDENT_DIV  = 125;
  localparam int SD_MIN_DIV    = 2;

  function automatic logic [15:0] sd_clamp_div(input logic [15:0] div,
                                               input logic [15:0] min_div);
    return (div < min_div) ? min_div : div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_clk_phase_split.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sd_clk_phase_split: clamps a divisor and splits it into high/low lengths   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sd_clk_phase_split
  import sd_host_pkg::*;
#(
  parameter int MIN_DIV = SD_MIN_DIV
) (
  input  logic [15:0] i_div,
  output logic [15:0] o_hi_len,
  output logic [15:0] o_lo_len
);

  localparam logic [15:0] C_MIN_DIV = 16'(MIN_DIV);

  logic [15:0] w_div;

  // Odd divisors put the extra cycle in the low phase.
  always_comb begin
    w_div    = sd_clamp_div(i_div, C_MIN_DIV);
    o_hi_len = {1'b0, w_div[15:1]};
    o_lo_len = w_div - o_hi_len;
  end

endmodule
`default_nettype wire

// File: rtl/sd_clk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sd_clk_gen: glitch-free SD bus clock with rise/fall strobes.               |
// | Optional SD_CLK_IDENT_FORCE_EN adds ident_mode forcing DEFAULT_DIV.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sd_clk_gen
  import sd_host_pkg::*;
#(
  parameter int DEFAULT_DIV = SD_IDENT_DIV,
  parameter int MIN_DIV     = SD_MIN_DIV
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] div_count,
  input  logic        div_ok,
  input  logic        div_err,
  input  logic        clk_en,
`ifdef SD_CLK_IDENT_FORCE_EN
  input  logic        ident_mode,
`endif
  output logic        sd_clk,
  output logic        sd_clk_rise,
  output logic        sd_clk_fall,
  output logic        running,
  output logic        div_fault
);

  localparam logic [15:0] C_DEFAULT_DIV = 16'(DEFAULT_DIV);

  sd_clk_state_t r_state, w_state_nxt;
  logic [15:0]   r_cnt, w_cnt_nxt;
  logic [15:0]   r_cur_div, r_pend_div;
  logic          r_pend_vld;
  logic          r_fault;
  logic          r_sd_clk, r_rise, r_fall, r_running;

  logic          w_at_apply, w_apply, w_pend_clr;
  logic [15:0]   w_apply_div, w_eff_div, w_hi_len, w_lo_len;

  // Divisor changes only land in IDLE or on the final LOW cycle.
  assign w_at_apply = (r_state == ST_IDLE) || ((r_state == ST_LOW) && (r_cnt == 16'd0));

`ifdef SD_CLK_IDENT_FORCE_EN
  assign w_apply     = w_at_apply && (ident_mode || r_pend_vld);
  assign w_apply_div = ident_mode ? C_DEFAULT_DIV : r_pend_div;
  assign w_pend_clr  = w_apply && !ident_mode;
`else
  assign w_apply     = w_at_apply && r_pend_vld;
  assign w_apply_div = r_pend_div;
  assign w_pend_clr  = w_apply;
`endif

  assign w_eff_div = w_apply ? w_apply_div : r_cur_div;

  sd_clk_phase_split #(
    .MIN_DIV (MIN_DIV)
  ) u_split (
    .i_div    (w_eff_div),
    .o_hi_len (w_hi_len),
    .o_lo_len (w_lo_len)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 16'd0;
        if (clk_en) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = w_hi_len - 16'd1;
        end
      end
      ST_HIGH: begin
        if (r_cnt == 16'd0) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = w_lo_len - 16'd1;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_LOW: begin
        if (r_cnt == 16'd0) begin
          if (clk_en) begin
            w_state_nxt = ST_HIGH;
            w_cnt_nxt   = w_hi_len - 16'd1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 16'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 16'd0;
      r_cur_div  <= C_DEFAULT_DIV;
      r_pend_div <= C_DEFAULT_DIV;
      r_pend_vld <= 1'b0;
      r_fault    <= 1'b0;
      r_sd_clk   <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_apply) begin
        r_cur_div <= w_apply_div;
      end
      if (w_pend_clr) begin
        r_pend_vld <= 1'b0;
      end
      // A fresh load in the apply cycle must survive the clear above.
      if (div_err) begin
        r_fault <= 1'b1;
      end else if (div_ok) begin
        r_pend_div <= div_count;
        r_pend_vld <= 1'b1;
        r_fault    <= 1'b0;
      end
      r_sd_clk  <= (w_state_nxt == ST_HIGH);
      r_rise    <= (w_state_nxt == ST_HIGH) && (r_state != ST_HIGH);
      r_fall    <= (w_state_nxt == ST_LOW) && (r_state == ST_HIGH);
      r_running <= (w_state_nxt != ST_IDLE);
    end
  end

  assign sd_clk      = r_sd_clk;
  assign sd_clk_rise = r_rise;
  assign sd_clk_fall = r_fall;
  assign running     = r_running;
  assign div_fault   = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_sd_clk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sd_clk_gen: directed self-checking bench for sd_clk_gen                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sd_clk_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] div_count;
  logic        div_ok, div_err, clk_en;
`ifdef SD_CLK_IDENT_FORCE_EN
  logic        ident_mode;
`endif
  logic        sd_clk, sd_clk_rise, sd_clk_fall, running, div_fault;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  sd_clk_gen dut (
    .clk         (clk),
    .reset       (reset),
    .div_count   (div_count),
    .div_ok      (div_ok),
    .div_err     (div_err),
    .clk_en      (clk_en),
`ifdef SD_CLK_IDENT_FORCE_EN
    .ident_mode  (ident_mode),
`endif
    .sd_clk      (sd_clk),
    .sd_clk_rise (sd_clk_rise),
    .sd_clk_fall (sd_clk_fall),
    .running     (running),
    .div_fault   (div_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rise(input string tag);
    int n = 0;
    while (sd_clk_rise !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sd_clk_rise !== 1'b1) check({tag, "_rise_timeout"}, 32'(sd_clk_rise), 1);
  endtask

  // Counts the high phase from the current cycle, then the low phase until
  // the next rise or until the clock parks.
  task automatic count_expect(input string tag, input int exp_hi, input int exp_lo);
    int hi = 0;
    int lo = 0;
    while (sd_clk === 1'b1 && hi < 400) begin
      hi++;
      @(negedge clk);
    end
    while (sd_clk === 1'b0 && running === 1'b1 && lo < 400) begin
      lo++;
      @(negedge clk);
    end
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  task automatic measure(input string tag, input int exp_hi, input int exp_lo);
    wait_rise(tag);
    count_expect(tag, exp_hi, exp_lo);
  endtask

  task automatic pulse_ok(input logic [15:0] v);
    div_count = v;
    div_ok    = 1'b1;
    @(negedge clk);
    div_ok    = 1'b0;
  endtask

  initial begin
    int rises;
    reset     = 1'b0;
    clk_en    = 1'b0;
    div_ok    = 1'b0;
    div_err   = 1'b0;
    div_count = 16'd0;
`ifdef SD_CLK_IDENT_FORCE_EN
    ident_mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_sd_clk", 32'(sd_clk), 0);
    check("rst_rise", 32'(sd_clk_rise), 0);
    check("rst_fall", 32'(sd_clk_fall), 0);
    check("rst_running", 32'(running), 0);
    check("rst_fault", 32'(div_fault), 0);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_sd_clk", 32'(sd_clk), 0);

    // Test 1: default divisor 125 -> 62 high / 63 low
    clk_en = 1'b1;
    @(negedge clk);
    check("t1_first_rise", 32'(sd_clk_rise), 1);
    check("t1_first_clk", 32'(sd_clk), 1);
    check("t1_running", 32'(running), 1);
    check("t1_no_fall", 32'(sd_clk_fall), 0);
    count_expect("t1", 62, 63);

    // Test 2: load 4 mid-HIGH, then 5
    pulse_ok(16'd4);
    count_expect("t2_rem", 61, 63);
    measure("t2_d4a", 2, 2);
    measure("t2_d4b", 2, 2);
    pulse_ok(16'd5);
    count_expect("t2_rem5", 1, 2);
    measure("t2_d5", 2, 3);

    // Test 3: clamp of 0 and 1, strobes alternate
    pulse_ok(16'd0);
    count_expect("t3_rem", 1, 3);
    measure("t3_d0", 1, 1);
    check("t3_alt_r0", 32'(sd_clk_rise), 1);
    check("t3_alt_f0", 32'(sd_clk_fall), 0);
    @(negedge clk);
    check("t3_alt_r1", 32'(sd_clk_rise), 0);
    check("t3_alt_f1", 32'(sd_clk_fall), 1);
    @(negedge clk);
    check("t3_alt_r2", 32'(sd_clk_rise), 1);
    check("t3_alt_f2", 32'(sd_clk_fall), 0);
    pulse_ok(16'd1);
    measure("t3_d1", 1, 1);

    // Test 4: div_err keeps the clock, div_ok clears the fault
    pulse_ok(16'd4);
    measure("t4_d4", 2, 2);
    div_err = 1'b1;
    @(negedge clk);
    div_err = 1'b0;
    check("t4_fault_set", 32'(div_fault), 1);
    count_expect("t4_after_err", 1, 2);
    measure("t4_d4_kept", 2, 2);
    pulse_ok(16'd8);
    check("t4_fault_clr", 32'(div_fault), 0);
    count_expect("t4_rem", 1, 2);
    measure("t4_d8", 4, 4);

    // Test 5: clk_en dropped in first HIGH cycle of a div-10 period
    pulse_ok(16'd10);
    count_expect("t5_rem", 3, 4);
    check("t5_start_rise", 32'(sd_clk_rise), 1);
    clk_en = 1'b0;
    count_expect("t5_d10", 5, 5);
    check("t5_parked_run", 32'(running), 0);
    check("t5_parked_clk", 32'(sd_clk), 0);
    rises = 0;
    repeat (20) begin
      @(negedge clk);
      if (sd_clk_rise === 1'b1 || sd_clk === 1'b1) rises++;
    end
    check("t5_stay_parked", rises, 0);

    // Reset mid-HIGH drops sd_clk on the next cycle
    clk_en = 1'b1;
    wait_rise("t5b");
    @(negedge clk);
    check("t5b_high", 32'(sd_clk), 1);
    reset = 1'b0;
    @(negedge clk);
    check("t5b_rst_clk", 32'(sd_clk), 0);
    check("t5b_rst_run", 32'(running), 0);
    reset = 1'b1;
    measure("t5b_post_rst", 62, 63);

`ifdef SD_CLK_IDENT_FORCE_EN
    // Test 6: ident_mode holds 125 until released
    ident_mode = 1'b1;
    pulse_ok(16'd4);
    count_expect("t6_rem", 61, 63);
    measure("t6_forced", 62, 63);
    ident_mode = 1'b0;
    count_expect("t6_release", 62, 63);
    measure("t6_d4", 2, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
